combo_lock_core: RTL and testbench

- Combination-lock controller; instantiated directly inside the Basys board top, between the button debouncers and the seven-segment/LED drivers.
- Takes single-cycle button pulses plus a hex digit from switches, accumulates an entered code and compares it to a stored code.
- Manages open/locked/programming/lockout states.
- Produces display data and status flags for the downstream display mux and LED array.

---
 rtl/combo_lock_pkg.sv | 39 +++
 rtl/combo_lock_core_lockout_timer.sv | 38 +++
 rtl/combo_lock_core.sv | 174 +++++++++++++++++
 tb/tb_combo_lock_core.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/combo_lock_pkg.sv
// combo_lock_pkg: shared types and helpers for the combination lock.
// State encoding, digit geometry and mask helpers.
package combo_lock_pkg;

  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 4;
  localparam int BUF_W      = DIGIT_W * MAX_DIGITS;

  typedef enum logic [2:0] {
    ST_LOCKED  = 3'd0,
    ST_CHECK   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_PROG    = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  // Nibble mask covering the low len digits of the entry buffer.
  function automatic logic [BUF_W-1:0] code_mask(input int len);
    logic [BUF_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < len) m[i*DIGIT_W +: DIGIT_W] = '1;
    end
    return m;
  endfunction

  // Display enable: bit i set when digit i holds an entered value.
  function automatic logic [MAX_DIGITS-1:0] digit_mask(
    input logic [2:0] cnt
  );
    logic [MAX_DIGITS-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      m[i] = (i < int'(cnt));
    end
    return m;
  endfunction

endpackage

// File: rtl/combo_lock_core_lockout_timer.sv
// lockout_timer: loadable down-counter for the lockout period.
// done is high while the count sits at zero.
module lockout_timer #(
  parameter int unsigned LOCKOUT_CYCLES = 500_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int TW =
    (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LOAD_VAL = TW'(LOCKOUT_CYCLES - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Load wins over decrement; count parks at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/combo_lock_core.sv
// combo_lock_core: code entry, compare, programming and lockout.
// Outputs decode straight from registered state.
module combo_lock_core
  import combo_lock_pkg::*;
#(
  parameter int unsigned CODE_LEN       = 4,
  parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
  parameter int unsigned MAX_FAIL       = 3,
  parameter int unsigned LOCKOUT_CYCLES = 500_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  digit_in,
  input  logic        enter_p,
  input  logic        clear_p,
  input  logic        lock_p,
  input  logic        prog_p,
  output logic        is_open,
  output logic        is_prog,
  output logic        is_lockout,
  output logic        err,
  output logic [2:0]  fail_cnt,
  output logic [2:0]  digit_cnt,
  output logic [15:0] disp_val,
  output logic [3:0]  disp_mask
);

  localparam logic [2:0] LEN  = 3'(CODE_LEN);
  localparam logic [2:0] MAXF = 3'(MAX_FAIL);
  localparam logic [BUF_W-1:0] CMASK = code_mask(int'(CODE_LEN));
  localparam logic [BUF_W-1:0] RST_CODE = DEFAULT_CODE & CMASK;

  state_e           state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [BUF_W-1:0] code_q, code_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [2:0]       fail_q, fail_d;
  logic             err_q, err_d;
  logic             tmr_load;
  logic             tmr_en;
  logic             tmr_done;
  logic             show;

  lockout_timer #(
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .load(tmr_load),
    .en  (tmr_en),
    .done(tmr_done)
  );

  // Next-state, entry buffer, compare and counters.
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    code_d   = code_q;
    cnt_d    = cnt_q;
    fail_d   = fail_q;
    err_d    = err_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    unique case (state_q)
      ST_LOCKED: begin
        if (cnt_q == LEN) begin
          state_d = ST_CHECK;
        end else if (clear_p) begin
          buf_d = '0;
          cnt_d = '0;
        end else if (enter_p) begin
          buf_d = {buf_q[BUF_W-DIGIT_W-1:0], digit_in};
          cnt_d = cnt_q + 3'd1;
          err_d = 1'b0;
        end
      end
      ST_CHECK: begin
        buf_d = '0;
        cnt_d = '0;
        if ((buf_q & CMASK) == code_q) begin
          state_d = ST_OPEN;
          fail_d  = '0;
          err_d   = 1'b0;
        end else begin
          err_d  = 1'b1;
          fail_d = (fail_q >= MAXF) ? MAXF : fail_q + 3'd1;
          if (fail_d == MAXF) begin
            state_d  = ST_LOCKOUT;
            tmr_load = 1'b1;
          end else begin
            state_d = ST_LOCKED;
          end
        end
      end
      ST_OPEN: begin
        if (lock_p) begin
          state_d = ST_LOCKED;
        end else if (prog_p) begin
          state_d = ST_PROG;
          buf_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_PROG: begin
        if (lock_p) begin
          state_d = ST_LOCKED;
          buf_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == LEN) begin
          code_d  = buf_q & CMASK;
          buf_d   = '0;
          cnt_d   = '0;
          state_d = ST_OPEN;
        end else if (clear_p) begin
          buf_d = '0;
          cnt_d = '0;
        end else if (enter_p) begin
          buf_d = {buf_q[BUF_W-DIGIT_W-1:0], digit_in};
          cnt_d = cnt_q + 3'd1;
          err_d = 1'b0;
        end
      end
      ST_LOCKOUT: begin
        tmr_en = 1'b1;
        buf_d  = '0;
        cnt_d  = '0;
        if (tmr_done) begin
          state_d = ST_LOCKED;
          fail_d  = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_LOCKED;
        buf_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Lock state registers; reset restores the default code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOCKED;
      buf_q   <= '0;
      code_q  <= RST_CODE;
      cnt_q   <= '0;
      fail_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
    end
  end

  // Entry digits are hidden while open or locked out.
  always_comb begin
    show = (state_q != ST_OPEN) && (state_q != ST_LOCKOUT);
  end

  assign is_open    = (state_q == ST_OPEN);
  assign is_prog    = (state_q == ST_PROG);
  assign is_lockout = (state_q == ST_LOCKOUT);
  assign err        = err_q;
  assign fail_cnt   = fail_q;
  assign digit_cnt  = cnt_q;
  assign disp_val   = show ? buf_q : '0;
  assign disp_mask  = show ? digit_mask(cnt_q) : '0;

endmodule

// File: tb/tb_combo_lock_core.sv
// tb_combo_lock_core: directed checks of the combination lock.
// Inputs change on falling edges; outputs sampled there too.
module tb_combo_lock_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  digit_in;
  logic        enter_p;
  logic        clear_p;
  logic        lock_p;
  logic        prog_p;
  logic        is_open;
  logic        is_prog;
  logic        is_lockout;
  logic        err;
  logic [2:0]  fail_cnt;
  logic [2:0]  digit_cnt;
  logic [15:0] disp_val;
  logic [3:0]  disp_mask;

  int n_tests = 0;
  int n_fail  = 0;
  int lo      = 0;
  int bad     = 0;

  combo_lock_core #(
    .CODE_LEN      (4),
    .DEFAULT_CODE  (16'h1234),
    .MAX_FAIL      (3),
    .LOCKOUT_CYCLES(20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .digit_in  (digit_in),
    .enter_p   (enter_p),
    .clear_p   (clear_p),
    .lock_p    (lock_p),
    .prog_p    (prog_p),
    .is_open   (is_open),
    .is_prog   (is_prog),
    .is_lockout(is_lockout),
    .err       (err),
    .fail_cnt  (fail_cnt),
    .digit_cnt (digit_cnt),
    .disp_val  (disp_val),
    .disp_mask (disp_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic o, input logic p, input logic l,
                         input logic e, input logic [2:0] f,
                         input logic [2:0] c, input logic [15:0] v,
                         input logic [3:0] m);
    chk({tag, ".open"}, 32'(is_open), 32'(o));
    chk({tag, ".prog"}, 32'(is_prog), 32'(p));
    chk({tag, ".lockout"}, 32'(is_lockout), 32'(l));
    chk({tag, ".err"}, 32'(err), 32'(e));
    chk({tag, ".fail"}, 32'(fail_cnt), 32'(f));
    chk({tag, ".cnt"}, 32'(digit_cnt), 32'(c));
    chk({tag, ".val"}, 32'(disp_val), 32'(v));
    chk({tag, ".mask"}, 32'(disp_mask), 32'(m));
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse(input logic e, input logic c,
                       input logic l, input logic p,
                       input logic [3:0] d);
    digit_in = d;
    enter_p  = e;
    clear_p  = c;
    lock_p   = l;
    prog_p   = p;
    tick();
    enter_p  = 1'b0;
    clear_p  = 1'b0;
    lock_p   = 1'b0;
    prog_p   = 1'b0;
  endtask

  task automatic enter(input logic [3:0] d);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, d);
  endtask

  task automatic enter4(input logic [15:0] code);
    logic [15:0] c;
    c = code;
    enter(c[15:12]);
    enter(c[11:8]);
    enter(c[7:4]);
    enter(c[3:0]);
  endtask

  initial begin
    rst      = 1'b1;
    digit_in = 4'h0;
    enter_p  = 1'b0;
    clear_p  = 1'b0;
    lock_p   = 1'b0;
    prog_p   = 1'b0;
    tick();
    tick();
    chk_all("in_reset", 0, 0, 0, 0, 3'd0, 3'd0, 16'h0, 4'h0);
    rst = 1'b0;
    tick();
    chk_all("post_reset", 0, 0, 0, 0, 3'd0, 3'd0, 16'h0, 4'h0);

    enter(4'h1);
    chk_all("d1", 0, 0, 0, 0, 3'd0, 3'd1, 16'h0001, 4'h1);
    enter(4'h2);
    enter(4'h3);
    chk_all("d3", 0, 0, 0, 0, 3'd0, 3'd3, 16'h0123, 4'h7);
    enter(4'h4);
    chk_all("d4", 0, 0, 0, 0, 3'd0, 3'd4, 16'h1234, 4'hF);
    tick();
    chk("lat_n1.open", 32'(is_open), 32'd0);
    tick();
    chk_all("opened", 1, 0, 0, 0, 3'd0, 3'd0, 16'h0, 4'h0);
    enter(4'h5);
    chk_all("open_ign", 1, 0, 0, 0, 3'd0, 3'd0, 16'h0, 4'h0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    chk("relock.open", 32'(is_open), 32'd0);

    enter4(16'h1235);
    tick();
    tick();
    chk_all("wrong1", 0, 0, 0, 1, 3'd1, 3'd0, 16'h0, 4'h0);
    enter(4'h1);
    chk_all("err_clr", 0, 0, 0, 0, 3'd1, 3'd1, 16'h0001, 4'h1);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    chk("clear.cnt", 32'(digit_cnt), 32'd0);

    enter4(16'h9999);
    tick();
    tick();
    chk_all("wrong2", 0, 0, 0, 1, 3'd2, 3'd0, 16'h0, 4'h0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    chk("clr_keep.err", 32'(err), 32'd1);
    chk("clr_keep.fail", 32'(fail_cnt), 32'd2);
    enter4(16'h9999);
    tick();
    tick();
    chk_all("lockout", 0, 0, 1, 1, 3'd3, 3'd0, 16'h0, 4'h0);
    digit_in = 4'h1;
    enter_p  = 1'b1;
    prog_p   = 1'b1;
    lo  = 0;
    bad = 0;
    for (int i = 0; i < 40 && is_lockout; i++) begin
      lo++;
      if (digit_cnt != 3'd0 || disp_mask != 4'h0) bad++;
      tick();
    end
    enter_p = 1'b0;
    prog_p  = 1'b0;
    chk("lockout.cycles", 32'(lo), 32'd20);
    chk("lockout.ignored", 32'(bad), 32'd0);
    chk_all("post_lockout", 0, 0, 0, 0, 3'd0, 3'd0, 16'h0, 4'h0);

    enter4(16'h1234);
    tick();
    tick();
    chk("reopen.open", 32'(is_open), 32'd1);
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
    chk_all("prog", 0, 1, 0, 0, 3'd0, 3'd0, 16'h0, 4'h0);
    enter(4'hA);
    enter(4'hB);
    chk_all("prog_ab", 0, 1, 0, 0, 3'd0, 3'd2, 16'h00AB, 4'h3);
    enter(4'hC);
    enter(4'hD);
    chk("prog_full.prog", 32'(is_prog), 32'd1);
    tick();
    chk_all("prog_done", 1, 0, 0, 0, 3'd0, 3'd0, 16'h0, 4'h0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    enter4(16'h1234);
    tick();
    tick();
    chk_all("old_code", 0, 0, 0, 1, 3'd1, 3'd0, 16'h0, 4'h0);
    enter4(16'hABCD);
    tick();
    tick();
    chk_all("new_code", 1, 0, 0, 0, 3'd0, 3'd0, 16'h0, 4'h0);

    pulse(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    enter(4'h7);
    enter(4'h7);
    chk("77.val", 32'(disp_val), 32'h0077);
    pulse(1'b1, 1'b1, 1'b0, 1'b0, 4'h7);
    chk("clr_pri.cnt", 32'(digit_cnt), 32'd0);
    chk("clr_pri.val", 32'(disp_val), 32'd0);
    enter4(16'hABCD);
    tick();
    tick();
    chk("open3.open", 32'(is_open), 32'd1);
    pulse(1'b0, 1'b0, 1'b1, 1'b1, 4'h0);
    chk("lock_pri.open", 32'(is_open), 32'd0);
    chk("lock_pri.prog", 32'(is_prog), 32'd0);

    enter4(16'hABCD);
    tick();
    tick();
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
    enter(4'h5);
    enter(4'h6);
    chk("midprog.cnt", 32'(digit_cnt), 32'd2);
    rst = 1'b1;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 3'd0, 3'd0, 16'h0, 4'h0);
    tick();
    rst = 1'b0;
    tick();
    enter4(16'h1234);
    tick();
    tick();
    chk_all("default_back", 1, 0, 0, 0, 3'd0, 3'd0, 16'h0, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
